serial_cmp_ctrl: RTL

Sequencer for the 2-bit magnitude-compare slice: compares two WIDTH-bit operands MSB-first, one 2-bit slice per clock, and stops at the first unequal slice. It presents a start/busy/done handshake to the surrounding logic. It drives the same 8-bit display pattern as the combinational comparator: 0xFF for greater, 0x0F for equal, 0x00 for less. The pattern is backed by explicit gt/eq/lt flags.

---
 rtl/serial_cmp_ctrl_pkg.sv | 17 +
 rtl/serial_cmp_ctrl_cmp2_slice.sv | 24 ++
 rtl/serial_cmp_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/serial_cmp_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_cmp_ctrl_pkg
// Shared constants for the serial 2-bit-slice magnitude comparator.
//   - FSM state encodings (IDLE / COMPARE / DONE)
//   - 8-bit display patterns driven on the result port
// -----------------------------------------------------------------------------
package serial_cmp_ctrl_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPARE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [7:0] PAT_GT = 8'hFF;
    localparam logic [7:0] PAT_EQ = 8'h0F;
    localparam logic [7:0] PAT_LT = 8'h00;

endpackage

// File: rtl/serial_cmp_ctrl_cmp2_slice.sv
// -----------------------------------------------------------------------------
// cmp2_slice
// Purely combinational 2-bit unsigned magnitude comparator.
// Ports:
//   x   [1:0] in  : slice of operand A
//   y   [1:0] in  : slice of operand B
//   sgt       out : x > y
//   seq       out : x == y
//   slt       out : x < y
// Exactly one of sgt/seq/slt is high for any input.
// -----------------------------------------------------------------------------
module cmp2_slice (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic       sgt,
    output logic       seq,
    output logic       slt
);

    assign sgt = (x > y);
    assign seq = (x == y);
    assign slt = (x < y);

endmodule

// File: rtl/serial_cmp_ctrl.sv
// -----------------------------------------------------------------------------
// serial_cmp_ctrl
// Compares two WIDTH-bit unsigned operands MSB-first, one 2-bit slice per
// clock, stopping at the first unequal slice. start/busy/done handshake.
// Ports:
//   clk            in  : rising-edge clock
//   rst            in  : synchronous active-high reset
//   start          in  : request a comparison (sampled only in IDLE)
//   a, b [WIDTH]   in  : operands, latched on the accepting edge
//   busy           out : high in COMPARE and DONE
//   done           out : one-cycle pulse, results valid from this cycle
//   gt, eq, lt     out : result flags (all zero before first completion)
//   o    [7:0]     out : display pattern 0xFF gt / 0x0F eq / 0x00 lt or none
//
// The idx-selected slice pair is registered before it reaches the slice
// comparator, so a decision at slice position k (k=0 is the MSB slice)
// leads to done being high in the cycle after edge E0+k+2, E0 being the
// accepting edge.
// -----------------------------------------------------------------------------
module serial_cmp_ctrl
    import serial_cmp_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [7:0]       o
);

    localparam int S     = WIDTH / 2;
    localparam int IDX_W = (S > 1) ? $clog2(S) : 1;

    logic [1:0]       state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [WIDTH-1:0] ra_reg;
    logic [WIDTH-1:0] rb_reg;
    logic [1:0]       sx_reg;
    logic [1:0]       sy_reg;
    logic             last_reg;    // slice held in sx/sy_reg is the LSB slice
    logic             primed_reg;  // sx/sy_reg hold a valid slice pair
    logic             busy_reg;
    logic             done_reg;
    logic             gt_reg;
    logic             eq_reg;
    logic             lt_reg;
    logic [7:0]       o_reg;

    logic [1:0] slice_a [S];
    logic [1:0] slice_b [S];
    logic       s_gt;
    logic       s_eq;
    logic       s_lt;

    generate
        for (genvar gi = 0; gi < S; gi++) begin : g_slice
            assign slice_a[gi] = ra_reg[2*gi+1 -: 2];
            assign slice_b[gi] = rb_reg[2*gi+1 -: 2];
        end
    endgenerate

    cmp2_slice u_cmp2_slice (
        .x   (sx_reg),
        .y   (sy_reg),
        .sgt (s_gt),
        .seq (s_eq),
        .slt (s_lt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= '0;
            ra_reg     <= '0;
            rb_reg     <= '0;
            sx_reg     <= '0;
            sy_reg     <= '0;
            last_reg   <= 1'b0;
            primed_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            gt_reg     <= 1'b0;
            eq_reg     <= 1'b0;
            lt_reg     <= 1'b0;
            o_reg      <= PAT_LT;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        ra_reg     <= a;
                        rb_reg     <= b;
                        idx_reg    <= IDX_W'(S - 1);
                        primed_reg <= 1'b0;
                        busy_reg   <= 1'b1;
                        gt_reg     <= 1'b0;
                        eq_reg     <= 1'b0;
                        lt_reg     <= 1'b0;
                        o_reg      <= PAT_LT;
                        state_reg  <= ST_COMPARE;
                    end
                end

                ST_COMPARE: begin
                    if (primed_reg && s_gt) begin
                        gt_reg    <= 1'b1;
                        o_reg     <= PAT_GT;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else if (primed_reg && s_lt) begin
                        lt_reg    <= 1'b1;
                        o_reg     <= PAT_LT;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else if (primed_reg && last_reg) begin
                        eq_reg    <= 1'b1;
                        o_reg     <= PAT_EQ;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        // Fetch the next slice pair; idx stops at 0 instead
                        // of wrapping since the LSB slice always ends the scan.
                        sx_reg     <= slice_a[idx_reg];
                        sy_reg     <= slice_b[idx_reg];
                        last_reg   <= (idx_reg == '0);
                        primed_reg <= 1'b1;
                        if (idx_reg != '0) begin
                            idx_reg <= idx_reg - IDX_W'(1);
                        end
                    end
                end

                ST_DONE: begin
                    done_reg   <= 1'b0;
                    busy_reg   <= 1'b0;
                    primed_reg <= 1'b0;
                    state_reg  <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign gt   = gt_reg;
    assign eq   = eq_reg;
    assign lt   = lt_reg;
    assign o    = o_reg;

endmodule
